// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - flip-flop register file, two combinational read ports, committed-write counter
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_bypass #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] read1RegSel,
    input  logic [$clog2(NREGS)-1:0] read2RegSel,
    input  logic [$clog2(NREGS)-1:0] writeRegSel,
    input  logic [WIDTH-1:0]         writeData,
    input  logic                     writeEn,
    output logic [WIDTH-1:0]         read1Data,
    output logic [WIDTH-1:0]         read2Data,
    output logic [WIDTH-1:0]         wrCount
);

    logic [WIDTH-1:0] regs [NREGS];

    // Reset wins over a simultaneous write; R0 is an ordinary register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wrCount <= '0;
        end else if (writeEn) begin
            regs[writeRegSel] <= writeData;
            wrCount           <= wrCount + WIDTH'(1);
        end
    end

`ifdef RF_BYPASS_EN
    logic wr_live;

    assign wr_live = writeEn && !rst;

    always_comb begin
        read1Data = regs[read1RegSel];
        read2Data = regs[read2RegSel];
        if (wr_live && (read1RegSel == writeRegSel)) begin
            read1Data = writeData;
        end
        if (wr_live && (read2RegSel == writeRegSel)) begin
            read2Data = writeData;
        end
    end
`else
    always_comb begin
        read1Data = regs[read1RegSel];
        read2Data = regs[read2RegSel];
    end
`endif

endmodule

// File: tb/tb_regfile_bypass.sv
// tb/tb_regfile_bypass.sv - randomized bench with array/counter reference model for regfile_bypass
module tb_regfile_bypass;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  s1 = '0;
    logic [2:0]  s2 = '0;
    logic [2:0]  ws = '0;
    logic [15:0] wd = '0;
    logic        we = 1'b0;
    logic [15:0] read1Data;
    logic [15:0] read2Data;
    logic [15:0] wrCount;

    logic [15:0] model [8];
    logic [15:0] mcount;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    regfile_bypass #(.WIDTH(16), .NREGS(8)) dut (
        .clk(clk),
        .rst(rst),
        .read1RegSel(s1),
        .read2RegSel(s2),
        .writeRegSel(ws),
        .writeData(wd),
        .writeEn(we),
        .read1Data(read1Data),
        .read2Data(read2Data),
        .wrCount(wrCount)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] sel);
        if (BYP && we && !rst && sel == ws) return wd;
        return model[sel];
    endfunction

    // Reference: plain array plus a modulo-2^16 count of accepted writes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] <= 16'h0000;
            mcount <= 16'h0000;
        end else if (we) begin
            model[ws] <= wd;
            mcount    <= mcount + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_read1", read1Data, exp_read(s1));
            check("cmp_read2", read2Data, exp_read(s2));
            check("cmp_count", wrCount, mcount);
        end
    end

    task automatic drive(input logic r, input logic e, input logic [2:0] w, input logic [15:0] d,
                         input logic [2:0] a, input logic [2:0] b);
        rst = r; we = e; ws = w; wd = d; s1 = a; s2 = b;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        tick; tick;
        chk_en = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        at_neg;
        check("reset_count", wrCount, 16'h0000);
        check("reset_r0", read1Data, 16'h0000);

        // write R3 then reset: everything back to zero
        drive(0, 1, 3, 16'h1234, 3, 3);
        tick;
        at_neg;
        check("wr_r3", read1Data, 16'h1234);
        drive(1, 0, 0, 0, 3, 3);
        tick;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 3'(i), 3'(7 - i));
            at_neg;
            check("rst_clear_r1", read1Data, 16'h0000);
            check("rst_clear_r2", read2Data, 16'h0000);
            tick;
        end
        check("rst_clear_count", wrCount, 16'h0000);

        // write/read on both ports
        drive(0, 1, 5, 16'hBEEF, 0, 0);
        tick;
        drive(0, 0, 0, 0, 5, 5);
        at_neg;
        check("r5_port1", read1Data, 16'hBEEF);
        check("r5_port2", read2Data, 16'hBEEF);
        check("count_one", wrCount, 16'h0001);
        tick;

        // same-cycle read of the register being written
        drive(0, 1, 2, 16'h0001, 0, 0);
        tick;
        drive(0, 1, 2, 16'hA5A5, 2, 0);
        at_neg;
        check("bypass_cycle", read1Data, BYP ? 16'hA5A5 : 16'h0001);
        tick;
        drive(0, 0, 0, 0, 2, 2);
        at_neg;
        check("bypass_next", read1Data, 16'hA5A5);
        check("count_three", wrCount, 16'h0003);
        tick;

        // reset beats write
        drive(1, 1, 7, 16'hFFFF, 7, 7);
        at_neg;
        check("rst_no_bypass", read1Data, 16'h0000);
        tick;
        drive(0, 0, 0, 0, 7, 7);
        at_neg;
        check("prio_r7", read1Data, 16'h0000);
        check("prio_count", wrCount, 16'h0000);
        tick;

        // R0 is writable
        drive(0, 1, 0, 16'h8000, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 1);
        at_neg;
        check("r0_write", read1Data, 16'h8000);
        tick;

        // random traffic, selects biased toward the write target
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] w;
            w = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), w, 16'($urandom),
                  ($urandom_range(0, 2) == 0) ? w : 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? w : 3'($urandom_range(0, 7)));
            tick;
        end

        // counter wrap
        drive(1, 0, 0, 0, 0, 0);
        tick;
        for (int i = 0; i < 65535; i++) begin
            drive(0, 1, 3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick;
        end
        drive(0, 0, 0, 0, 0, 0);
        at_neg;
        check("count_ffff", wrCount, 16'hFFFF);
        drive(0, 1, 4, 16'h5A5A, 4, 4);
        tick;
        drive(0, 0, 0, 0, 4, 4);
        at_neg;
        check("count_wrap", wrCount, 16'h0000);
        check("wrap_write_r4", read1Data, 16'h5A5A);
        tick;

        // writeEn low: nothing changes whatever the data does
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 4, (i % 2 == 1) ? 16'hFFFF : 16'h0000, 4, 3'(i % 8));
            tick;
        end
        at_neg;
        check("gated_count", wrCount, 16'h0000);
        check("gated_r4", read1Data, 16'h5A5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 The block SHALL have parameter: WIDTH, 16, data width of each register and of every data port.
REQ-002 The block SHALL have parameter: NREGS, 8, register count; select ports are log2(NREGS) = 3 bits wide.
REQ-003 The block SHALL have port: clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port: read1RegSel  input  3  register index for read port 1, which feeds ALU operand A.
REQ-006 The block SHALL have port: read2RegSel  input  3  register index for read port 2, which feeds ALU operand B.
REQ-007 The block SHALL have port: writeRegSel  input  3  destination register index.
REQ-008 The block SHALL have port: writeData  input  WIDTH  writeback value (ALU result, memory data or link PC).
REQ-009 The block SHALL have port: writeEn  input  1  commit writeData to writeRegSel at the next clock edge.
REQ-010 The block SHALL have port: read1Data  output  WIDTH  contents of register read1RegSel.
REQ-011 The block SHALL have port: read2Data  output  WIDTH  contents of register read2RegSel.
REQ-012 The block SHALL have port: wrCount  output  WIDTH  count of committed writes since reset, wrapping modulo 2^WIDTH.

Function
REQ-013 The block SHALL hold NREGS registers of WIDTH bits each, implemented as flip-flops.
REQ-014 R0 SHALL be an ordinary register: no hardwired zero; writes to R0 take effect like writes to any other register.
REQ-015 Both read ports SHALL be combinational with zero-cycle latency from a select change to the data output, so the ALU consumes operands in the same cycle.
REQ-016 The two read ports SHALL be independent; read1RegSel equal to read2RegSel SHALL return identical data on both ports.
REQ-017 A write SHALL occur only on a rising clk edge with writeEn=1 and rst=0; it SHALL update exactly one register.
REQ-018 A write SHALL be visible through the register array no later than the cycle after the edge that committed it.
REQ-019 With writeEn=0 the array SHALL be unchanged, regardless of writeRegSel and writeData.
REQ-020 wrCount SHALL increment by 1 on each committed write.
REQ-021 wrCount SHALL wrap from 0xFFFF to 0x0000.
REQ-022 wrCount SHALL NOT increment during rst.
REQ-023 Same-cycle read of the register being written SHALL follow REQ-031/REQ-032.

Reset
REQ-024 When rst=1 at a rising edge, all registers SHALL become 0x0000.
REQ-025 When rst=1 at a rising edge, wrCount SHALL become 0x0000.
REQ-026 rst SHALL take priority over a simultaneous writeEn=1; the write SHALL be dropped.
REQ-027 Read ports SHALL remain combinational during reset, reflecting the array contents, which are 0x0000 from the cycle after the reset edge.
REQ-028 Deasserting rst mid-program SHALL require no recovery cycle; writes are accepted on the first edge with rst=0.

Configuration
REQ-029 Macro RF_BYPASS_EN SHALL select write-to-read bypass.
REQ-030 The macro SHALL be undefined by default.
REQ-031 With RF_BYPASS_EN defined: when writeEn=1, rst=0 and readNRegSel==writeRegSel, readNData SHALL equal writeData in that same cycle; each port SHALL be bypassed independently.
REQ-032 With RF_BYPASS_EN undefined: readNData SHALL return the pre-write register contents in the write cycle and the new value from the following cycle.
REQ-033 Bypass SHALL be suppressed while rst=1.

Verification
REQ-034 Reset: rst=1 for 1 edge after writing R3=0x1234 -> read1Data=read2Data=0x0000 for all selects; wrCount=0x0000.
REQ-035 Write/read: write R5=0xBEEF; next cycle read1Sel=5, read2Sel=5 -> both 0xBEEF; wrCount=1.
REQ-036 Bypass: in the write cycle, read1Sel=2 while writing R2=0xA5A5 with old R2=0x0001 -> 0xA5A5 with RF_BYPASS_EN, 0x0001 without; 0xA5A5 next cycle in both builds.
REQ-037 Priority: rst=1 and writeEn=1 writing R7=0xFFFF on the same edge -> R7=0x0000; wrCount=0x0000.
REQ-038 Gating and wrap: 0xFFFF committed writes -> wrCount=0xFFFF; one more write -> 0x0000; writeEn=0 with writeData toggling -> array and wrCount unchanged.
REQ-039 R0: write R0=0x8000 -> read1Sel=0 returns 0x8000 on the next cycle.
